// File: rtl/aurora_stream_traffic.sv
// Aurora 8b10b streaming traffic generator and self-synchronising checker.
// Per-lane counter / LFSR / walking-one patterns on TX, lock-and-count on RX.
module aurora_stream_traffic #(
  parameter int N_LANE       = 1,
  parameter int LANE_WIDTH   = 16,
  parameter int DATA_WIDTH   = LANE_WIDTH * N_LANE,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  USER_CLK,
  input  logic                  RESET,
  input  logic                  CHANNEL_UP,
  input  logic [1:0]            MODE,
  input  logic                  TX_ENABLE,
  input  logic                  CLEAR,
  output logic [0:DATA_WIDTH-1] TX_D,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  input  logic [0:DATA_WIDTH-1] RX_D,
  input  logic                  RX_SRC_RDY_N,
  output logic                  LOCKED,
  output logic                  ERR_FLAG,
  output logic [0:N_LANE-1]     LANE_ERR,
  output logic [CNT_WIDTH-1:0]  ERR_COUNT,
  output logic [CNT_WIDTH-1:0]  RX_WORDS
);

  typedef logic [LANE_WIDTH-1:0] word_t;

  localparam logic [1:0] M_CNT  = 2'b00;
  localparam logic [1:0] M_LFSR = 2'b01;
  localparam logic [1:0] M_WALK = 2'b10;
  localparam logic [1:0] M_IDLE = 2'b11;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_COUNT - 1);
  localparam logic [MW-1:0] M_ONE     = MW'(1);
  localparam logic [BW-1:0] B_ONE     = BW'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  function automatic word_t next_of(input logic [1:0] m, input word_t x);
    word_t r;
    case (m)
      M_LFSR:  r = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
      M_WALK:  r = {x[14:0], x[15]};
      default: r = x + word_t'(1);
    endcase
    return r;
  endfunction

  function automatic word_t seed_of(input logic [1:0] m, input int k);
    word_t r;
    case (m)
      M_LFSR:  r = 16'hACE1 + word_t'(k);
      M_WALK:  r = word_t'(1) << (k % 16);
      default: r = word_t'(k);
    endcase
    return r;
  endfunction

  logic [1:0]     mode_q;
  logic           src_rdy_n_q;
  word_t          gen_q [N_LANE];

  logic [0:0]     state_q;
  logic           started_q;
  logic [MW-1:0]  match_q;
  logic [BW-1:0]  bad_q;
  word_t          pred_q [N_LANE];

  word_t          rx_w [N_LANE];
  logic [0:N_LANE-1] lane_mis;
  logic           any_mis;
  logic           mode_chg;
  logic           reload;
  logic           tx_valid;
  logic           xfer;
  logic           force_hunt;
  logic           sample;
  logic           lock_now;
  logic           word_err;

  assign mode_chg   = (MODE != mode_q);
  assign reload     = !CHANNEL_UP || mode_chg;
  assign tx_valid   = CHANNEL_UP && TX_ENABLE && (MODE != M_IDLE);
  assign xfer       = !src_rdy_n_q && !TX_DST_RDY_N;
  assign force_hunt = !CHANNEL_UP || mode_chg || (MODE == M_IDLE);
  assign sample     = !RX_SRC_RDY_N && !force_hunt;

  always_comb begin
    TX_D = '0;
    for (int k = 0; k < N_LANE; k++)
      TX_D[k*LANE_WIDTH +: LANE_WIDTH] = gen_q[k];
  end

  always_comb begin
    rx_w     = '{default: '0};
    lane_mis = '0;
    for (int k = 0; k < N_LANE; k++) begin
      rx_w[k]     = RX_D[k*LANE_WIDTH +: LANE_WIDTH];
      lane_mis[k] = (rx_w[k] != pred_q[k]);
    end
  end

  assign any_mis  = |lane_mis;
  assign lock_now = sample && (state_q == HUNT) && started_q
                    && !any_mis && (match_q == LOCK_LAST);
  assign word_err = sample && (state_q == LOCK) && any_mis;

  assign TX_SRC_RDY_N = src_rdy_n_q;
  assign LOCKED       = (state_q == LOCK);

  // Seed reload takes priority over an advance in the same cycle.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      mode_q      <= M_CNT;
      src_rdy_n_q <= 1'b1;
      for (int k = 0; k < N_LANE; k++)
        gen_q[k] <= seed_of(M_CNT, k);
    end else begin
      mode_q      <= MODE;
      src_rdy_n_q <= !tx_valid;
      for (int k = 0; k < N_LANE; k++) begin
        if (reload)
          gen_q[k] <= seed_of(MODE, k);
        else if (xfer)
          gen_q[k] <= next_of(mode_q, gen_q[k]);
      end
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state_q   <= HUNT;
      started_q <= 1'b0;
      match_q   <= '0;
      bad_q     <= '0;
      for (int k = 0; k < N_LANE; k++)
        pred_q[k] <= '0;
    end else if (force_hunt) begin
      state_q   <= HUNT;
      started_q <= 1'b0;
      match_q   <= '0;
      bad_q     <= '0;
    end else if (sample) begin
      if (state_q == HUNT) begin
        for (int k = 0; k < N_LANE; k++)
          pred_q[k] <= next_of(mode_q, rx_w[k]);
        if (!started_q) begin
          started_q <= 1'b1;
          match_q   <= '0;
        end else if (any_mis) begin
          match_q <= '0;
        end else if (match_q == LOCK_LAST) begin
          state_q <= LOCK;
          match_q <= '0;
          bad_q   <= '0;
        end else begin
          match_q <= match_q + M_ONE;
        end
      end else begin
        // Free-running prediction: one bad word costs exactly one error.
        for (int k = 0; k < N_LANE; k++)
          pred_q[k] <= next_of(mode_q, pred_q[k]);
        if (!any_mis) begin
          bad_q <= '0;
        end else if (bad_q == BAD_LAST) begin
          state_q   <= HUNT;
          started_q <= 1'b0;
          bad_q     <= '0;
        end else begin
          bad_q <= bad_q + B_ONE;
        end
      end
    end
  end

  // The word that completes lock is counted as received while locked.
  always_ff @(posedge USER_CLK) begin
    if (RESET || CLEAR) begin
      ERR_COUNT <= '0;
      RX_WORDS  <= '0;
      ERR_FLAG  <= 1'b0;
      LANE_ERR  <= '0;
    end else begin
      if (word_err) begin
        ERR_FLAG <= 1'b1;
        LANE_ERR <= LANE_ERR | lane_mis;
        if (ERR_COUNT != '1)
          ERR_COUNT <= ERR_COUNT + C_ONE;
      end
      if (sample && (state_q == LOCK || lock_now) && RX_WORDS != '1)
        RX_WORDS <= RX_WORDS + C_ONE;
    end
  end

endmodule

// File: tb/tb_aurora_stream_traffic.sv
// Bench for aurora_stream_traffic: TX looped to RX, three lanes,
// plus a 4-bit-counter instance for saturation and clear priority.
module tb_aurora_stream_traffic;

  logic        clk = 1'b0;
  logic        rst, chan, tx_en, clr, dst_n, drop;
  logic [1:0]  mode;
  logic [0:47] flip, bad2;

  logic [0:47] tx_d, tx_d2, rx_d, rx_d2;
  logic        tx_srn, tx_srn2, rx_srn;
  logic        locked, locked2, err_flag, err_flag2;
  logic [0:2]  lane_err, lane_err2;
  logic [31:0] err_cnt, rx_words;
  logic [3:0]  err_cnt2, rx_words2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rx_d   = tx_d ^ flip;
  assign rx_d2  = tx_d ^ bad2;
  assign rx_srn = tx_srn | dst_n | drop;

  aurora_stream_traffic #(.N_LANE(3), .LOCK_COUNT(4), .UNLOCK_COUNT(8),
                          .CNT_WIDTH(32)) u_dut (
    .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(chan), .MODE(mode),
    .TX_ENABLE(tx_en), .CLEAR(clr), .TX_D(tx_d), .TX_SRC_RDY_N(tx_srn),
    .TX_DST_RDY_N(dst_n), .RX_D(rx_d), .RX_SRC_RDY_N(rx_srn),
    .LOCKED(locked), .ERR_FLAG(err_flag), .LANE_ERR(lane_err),
    .ERR_COUNT(err_cnt), .RX_WORDS(rx_words));

  aurora_stream_traffic #(.N_LANE(3), .LOCK_COUNT(4), .UNLOCK_COUNT(20),
                          .CNT_WIDTH(4)) u_sat (
    .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(chan), .MODE(mode),
    .TX_ENABLE(tx_en), .CLEAR(clr), .TX_D(tx_d2), .TX_SRC_RDY_N(tx_srn2),
    .TX_DST_RDY_N(dst_n), .RX_D(rx_d2), .RX_SRC_RDY_N(rx_srn),
    .LOCKED(locked2), .ERR_FLAG(err_flag2), .LANE_ERR(lane_err2),
    .ERR_COUNT(err_cnt2), .RX_WORDS(rx_words2));

  typedef struct {
    logic [1:0] mode;
    logic       chan;
    logic       dst_n;
    logic       drop;
    logic       clr;
    int         cyc;
    logic       e_srn;
    logic       e_lock;
    int         e_err;
    logic [2:0] e_lane;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [15:0] nxt(input logic [1:0] m, input logic [15:0] x);
    if (m == 2'd1) return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    if (m == 2'd2) return {x[14:0], x[15]};
    return x + 16'd1;
  endfunction

  function automatic logic [15:0] seed(input logic [1:0] m, input int k);
    if (m == 2'd1) return 16'hACE1 + 16'(k);
    if (m == 2'd2) return 16'h0001 << (k % 16);
    return 16'(k);
  endfunction

  function automatic logic [15:0] adv(input logic [1:0] m, input int k, input int n);
    logic [15:0] x;
    x = seed(m, k);
    for (int i = 0; i < n; i++) x = nxt(m, x);
    return x;
  endfunction

  function automatic logic [15:0] lane(input logic [0:47] v, input int k);
    return v[k*16 +: 16];
  endfunction

  function automatic logic [0:47] mk_lane(input int k, input logic [15:0] w);
    logic [0:47] r;
    r = '0;
    r[k*16 +: 16] = w;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_tx(input string name, input logic [1:0] m, input int n);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s lane%0d", name, k), lane(tx_d, k), adv(m, k, n));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tbl[0]  = '{2'd0, 1, 0, 0, 1, 1,  0, 0, 0, 3'b000};
    tbl[1]  = '{2'd0, 1, 0, 0, 0, 5,  0, 1, 0, 3'b000};
    tbl[2]  = '{2'd0, 1, 0, 0, 0, 5,  0, 1, 0, 3'b000};
    tbl[3]  = '{2'd0, 1, 0, 1, 0, 1,  0, 1, 0, 3'b000};
    tbl[4]  = '{2'd0, 1, 0, 0, 0, 7,  0, 1, 7, 3'b111};
    tbl[5]  = '{2'd0, 1, 0, 0, 0, 1,  0, 0, 8, 3'b111};
    tbl[6]  = '{2'd0, 1, 0, 0, 0, 4,  0, 0, 8, 3'b111};
    tbl[7]  = '{2'd0, 1, 0, 0, 0, 1,  0, 1, 8, 3'b111};
    tbl[8]  = '{2'd0, 1, 0, 0, 0, 20, 0, 1, 8, 3'b111};
    tbl[9]  = '{2'd3, 1, 0, 0, 0, 1,  1, 0, 8, 3'b111};
    tbl[10] = '{2'd3, 1, 0, 0, 0, 3,  1, 0, 8, 3'b111};
    tbl[11] = '{2'd0, 1, 0, 0, 0, 1,  0, 0, 8, 3'b111};
    tbl[12] = '{2'd0, 1, 0, 0, 0, 5,  0, 1, 8, 3'b111};

    rst = 1; chan = 0; mode = 2'd0; tx_en = 0; clr = 0;
    dst_n = 1; drop = 0; flip = '0; bad2 = '0;
    step(2);

    // Reset state
    chk("rst srn", tx_srn, 1'b1);
    chk("rst lane0", lane(tx_d, 0), 16'h0000);
    chk("rst lane1", lane(tx_d, 1), 16'h0001);
    chk("rst lane2", lane(tx_d, 2), 16'h0002);
    chk("rst locked", locked, 1'b0);
    chk("rst flag", err_flag, 1'b0);
    chk("rst lane_err", lane_err, 3'b000);
    chk("rst err_cnt", err_cnt, 0);
    chk("rst rx_words", rx_words, 0);

    // Counter mode loopback
    rst = 0; chan = 1; tx_en = 1; dst_n = 0;
    step(1);
    chk("cnt srn", tx_srn, 1'b0);
    chk_tx("cnt first", 2'd0, 0);
    step(4);
    chk("cnt lock@4", locked, 1'b0);
    step(1);
    chk("cnt lock@5", locked, 1'b1);
    chk_tx("cnt tx5", 2'd0, 5);
    step(995);
    chk("cnt err1000", err_cnt, 0);
    chk("cnt words1000", rx_words, 996);
    chk("cnt lane0 1000", lane(tx_d, 0), 16'h03E8);
    chk_tx("cnt tx1000", 2'd0, 1000);

    // LFSR mode: single bit flip in lane 1
    mode = 2'd1;
    step(1);
    chk_tx("lfsr seed", 2'd1, 0);
    chk("lfsr unlock", locked, 1'b0);
    step(5);
    chk("lfsr lock", locked, 1'b1);
    chk_tx("lfsr tx5", 2'd1, 5);
    flip = mk_lane(1, 16'h0008);
    step(1);
    flip = '0;
    step(5);
    chk("flip err_cnt", err_cnt, 1);
    chk("flip lane_err", lane_err, 3'b010);
    chk("flip flag", err_flag, 1'b1);
    chk("flip locked", locked, 1'b1);

    // Back-pressure hold
    dst_n = 1;
    step(1);
    chk_tx("hold1", 2'd1, 11);
    chk("hold srn", tx_srn, 1'b0);
    step(9);
    chk_tx("hold10", 2'd1, 11);
    dst_n = 0;
    step(5);
    chk_tx("resume", 2'd1, 16);
    chk("resume err", err_cnt, 1);
    chk("resume locked", locked, 1'b1);

    // Table: counter slip, unlock, relock, idle mode
    for (int i = 0; i < 13; i++) begin
      mode = tbl[i].mode; chan = tbl[i].chan; dst_n = tbl[i].dst_n;
      drop = tbl[i].drop; clr = tbl[i].clr;
      step(tbl[i].cyc);
      chk($sformatf("v%0d srn", i), tx_srn, tbl[i].e_srn);
      chk($sformatf("v%0d lock", i), locked, tbl[i].e_lock);
      chk($sformatf("v%0d err", i), err_cnt, tbl[i].e_err);
      chk($sformatf("v%0d lane", i), lane_err, tbl[i].e_lane);
      chk($sformatf("v%0d flag", i), err_flag, tbl[i].e_err != 0);
    end
    drop = 0; clr = 0;

    // 4-bit counter saturation, then CLEAR racing an error
    chk("sat pre lock", locked2, 1'b1);
    clr = 1;
    step(1);
    clr = 0;
    chk("sat cleared", err_cnt2, 4'd0);
    bad2 = mk_lane(2, 16'h0100);
    step(15);
    chk("sat 15", err_cnt2, 4'd15);
    chk("sat locked", locked2, 1'b1);
    step(3);
    chk("sat hold", err_cnt2, 4'd15);
    clr = 1;
    step(1);
    clr = 0;
    chk("clr wins", err_cnt2, 4'd0);
    chk("clr main err", err_cnt, 0);
    chk("clr main lane", lane_err, 3'b000);
    chk("clr main flag", err_flag, 1'b0);
    chk("clr main lock", locked, 1'b1);
    step(1);
    chk("sat unlock err", err_cnt2, 4'd1);
    chk("sat unlock", locked2, 1'b0);
    chk("sat lane_err", lane_err2, 3'b001);
    bad2 = '0;

    // Walking-one, channel drop and reset mid-stream
    mode = 2'd2;
    step(1);
    chk_tx("walk seed", 2'd2, 0);
    chk("walk lane2", lane(tx_d, 2), 16'h0004);
    step(5);
    chk("walk lock", locked, 1'b1);
    chk_tx("walk tx5", 2'd2, 5);
    step(3);
    chan = 0;
    step(1);
    chk("chdn srn", tx_srn, 1'b1);
    chk("chdn lock", locked, 1'b0);
    chk("chdn lane0", lane(tx_d, 0), 16'h0001);
    chk("chdn lane1", lane(tx_d, 1), 16'h0002);
    chan = 1;
    step(1);
    chk("chup srn", tx_srn, 1'b0);
    chk_tx("chup seed", 2'd2, 0);
    step(5);
    chk("chup relock", locked, 1'b1);
    rst = 1;
    step(1);
    chk("mrst srn", tx_srn, 1'b1);
    chk("mrst lock", locked, 1'b0);
    chk_tx("mrst cnt seed", 2'd0, 0);
    rst = 0;
    step(1);
    chk("rst2 srn", tx_srn, 1'b0);
    chk("rst2 lane0", lane(tx_d, 0), 16'h0001);
    chk("rst2 lane1", lane(tx_d, 1), 16'h0002);
    step(5);
    chk("rst2 relock", locked, 1'b1);
    chk("rst2 err", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
